// File: rtl/pipeline_pkg.sv
// Shared forwarding select codes, register-index constants and stage payload type.
package pipeline_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;

  localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } stage_info_t;

endpackage

// File: rtl/fwd_select.sv
// Priority compare for one ALU operand: EX/MEM result first, then MEM/WB, else regfile.
module fwd_select
  import pipeline_pkg::*;
#(
  parameter int unsigned          IDX_W    = 5,
  parameter logic [IDX_W-1:0]     ZERO_IDX = IDX_W'(31)
) (
  input  logic [IDX_W-1:0] i_src,
  input  logic             i_uses,
  input  logic [IDX_W-1:0] i_mem_rd,
  input  logic             i_mem_reg_write,
  input  logic [IDX_W-1:0] i_wb_rd,
  input  logic             i_wb_reg_write,
  output logic [1:0]       o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_uses && i_mem_reg_write && (i_mem_rd == i_src) && (i_mem_rd != ZERO_IDX);
  assign w_wb_hit  = i_uses && i_wb_reg_write  && (i_wb_rd  == i_src) && (i_wb_rd  != ZERO_IDX);

  always_comb begin
    o_sel = FWD_REGFILE;
    if (w_mem_hit) begin
      o_sel = FWD_EXMEM;
    end else if (w_wb_hit) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Tracks EX/MEM/WB destination state, drives operand forward selects,
// detects load-use hazards and counts stall cycles.
module hazard_forward_unit #(
  parameter int unsigned      REG_W    = 5,
  parameter logic [REG_W-1:0] ZERO_REG = REG_W'(pipeline_pkg::ZERO_REG),
  parameter int unsigned      CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             id_alu_src,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  pipeline_pkg::stage_info_t r_ex;
  logic [REG_W-1:0]          r_ex_rn;
  logic [REG_W-1:0]          r_ex_rm;
  logic                      r_ex_uses_rn;
  logic                      r_ex_uses_rm;
  logic                      r_ex_alu_src;
  logic [REG_W-1:0]          r_mem_rd;
  logic                      r_mem_reg_write;
  logic [REG_W-1:0]          r_wb_rd;
  logic                      r_wb_reg_write;
  logic [CNT_W-1:0]          r_stall_count;

  logic w_ex_load;
  logic w_src_hit;
  logic w_stall;

  // Load in EX whose result the ID instruction needs next cycle; flush squashes the consumer.
  assign w_ex_load = r_ex.valid && r_ex.mem_read && r_ex.reg_write && (r_ex.rd != ZERO_REG);
  assign w_src_hit = (id_uses_rn && (id_rn == r_ex.rd)) || (id_uses_rm && (id_rm == r_ex.rd));
  assign w_stall   = w_ex_load && w_src_hit && id_valid && !flush;

  assign stall       = w_stall;
  assign stall_count = r_stall_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex            <= '0;
      r_ex_rn         <= '0;
      r_ex_rm         <= '0;
      r_ex_uses_rn    <= 1'b0;
      r_ex_uses_rm    <= 1'b0;
      r_ex_alu_src    <= 1'b0;
      r_mem_rd        <= '0;
      r_mem_reg_write <= 1'b0;
      r_wb_rd         <= '0;
      r_wb_reg_write  <= 1'b0;
      r_stall_count   <= '0;
    end else begin
      r_mem_rd        <= r_ex.rd;
      r_mem_reg_write <= r_ex.reg_write;
      r_wb_rd         <= r_mem_rd;
      r_wb_reg_write  <= r_mem_reg_write;

      if (w_stall || flush) begin
        r_ex         <= '0;
        r_ex_rn      <= '0;
        r_ex_rm      <= '0;
        r_ex_uses_rn <= 1'b0;
        r_ex_uses_rm <= 1'b0;
        r_ex_alu_src <= 1'b0;
      end else begin
        r_ex.valid     <= id_valid;
        r_ex.rd        <= id_rd;
        r_ex.reg_write <= id_reg_write && id_valid;
        r_ex.mem_read  <= id_mem_read && id_valid;
        r_ex_rn        <= id_rn;
        r_ex_rm        <= id_rm;
        r_ex_uses_rn   <= id_uses_rn && id_valid;
        r_ex_uses_rm   <= id_uses_rm && id_valid;
        r_ex_alu_src   <= id_alu_src;
      end

      if (w_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  fwd_select #(
    .IDX_W    (REG_W),
    .ZERO_IDX (ZERO_REG)
  ) u_fwd_a (
    .i_src           (r_ex_rn),
    .i_uses          (r_ex_uses_rn),
    .i_mem_rd        (r_mem_rd),
    .i_mem_reg_write (r_mem_reg_write),
    .i_wb_rd         (r_wb_rd),
    .i_wb_reg_write  (r_wb_reg_write),
    .o_sel           (forwardA)
  );

  // Immediate on ALU input 2 must never be overridden by a forward.
  fwd_select #(
    .IDX_W    (REG_W),
    .ZERO_IDX (ZERO_REG)
  ) u_fwd_b (
    .i_src           (r_ex_rm),
    .i_uses          (r_ex_uses_rm && !r_ex_alu_src),
    .i_mem_rd        (r_mem_rd),
    .i_mem_reg_write (r_mem_reg_write),
    .i_wb_rd         (r_wb_rd),
    .i_wb_reg_write  (r_wb_reg_write),
    .o_sel           (forwardB)
  );

endmodule
